pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 4: register-address width; the register file holds 2**REG_AW registers.
REQ-002 Parameter ZERO_REG, default 1: when 1, register 0 is hard-wired and never causes a hazard or a forward.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_valid  in  1  a real instruction is in ID.
REQ-008 id_rs, id_rt  in  REG_AW each  source registers of the ID instruction.
REQ-009 id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads rs / rt.
REQ-010 id_rd  in  REG_AW  destination register of the ID instruction.
REQ-011 id_regwrite, id_memread  in  1 each  the ID instruction writes a register / loads from memory.
REQ-012 ex_branch_taken  in  1  the branch or jump in EX is taken this cycle.
REQ-013 pc_write, ifid_write  out  1 each  PC and IF/ID load enables.
REQ-014 idex_bubble  out  1  insert a NOP into ID/EX.
REQ-015 ifid_flush, idex_flush  out  1 each  squash IF/ID and ID/EX.
REQ-016 fwd_a, fwd_b  out  2 each  EX operand select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-017 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 Tracking registers EX, MEM and WB SHALL each hold {valid, rd, regwrite, memread}; EX SHALL additionally hold {rs, rt, use_rs, use_rt}.
REQ-019 A stage "writes r" SHALL mean valid & regwrite & rd==r & !(ZERO_REG & r==0).
REQ-020 The load-use hazard SHALL be: id_valid & EX.memread & EX writes a register that ID uses (id_rs with id_use_rs, or id_rt with id_use_rt).
REQ-021 stall SHALL equal the hazard condition & !ex_branch_taken; all of pc_write, ifid_write, idex_bubble, ifid_flush and idex_flush are combinational.
REQ-022 On stall: pc_write=0, ifid_write=0, idex_bubble=1; otherwise pc_write=1, ifid_write=1, idex_bubble=0.
REQ-023 On ex_branch_taken: ifid_flush=1 and idex_flush=1, regardless of any hazard; both SHALL be 0 otherwise.
REQ-024 Each clock: WB<=MEM and MEM<=EX; EX<=ID fields when id_valid & !stall & !ex_branch_taken, otherwise EX.valid<=0.
REQ-025 fwd_a SHALL be 01 if EX.use_rs & MEM writes EX.rs; otherwise 10 if WB writes EX.rs; otherwise 00; MEM has priority over WB.
REQ-026 fwd_b SHALL follow the same rule as fwd_a, using rt and use_rt.
REQ-027 fwd_a and fwd_b SHALL be 00 when EX.valid=0.
REQ-028 stall_cnt SHALL increment by 1 on each clock where stall=1 and SHALL hold at 2**CNT_W-1 once reached.
REQ-029 A load followed by a dependent instruction SHALL cost exactly 1 stall cycle with forwarding enabled.

Reset
REQ-030 While rst=1 at a clock edge: all valid bits<=0, all stored fields<=0, stall_cnt<=0.
REQ-031 After reset, before the first edge with rst=0: pc_write=1, ifid_write=1, idex_bubble=0, both flushes=0, fwd_a=fwd_b=00.
REQ-032 rst asserted mid-stall SHALL discard all in-flight tracking; the next cycle starts clean.

Configuration
REQ-033 Macro PIPE_HAZARD_FWD_EN defined: forwarding per REQ-025..029.
REQ-034 Macro PIPE_HAZARD_FWD_EN undefined: fwd_a=fwd_b=00 permanently.
REQ-035 Without PIPE_HAZARD_FWD_EN, the hazard condition SHALL be: id_valid & (EX or MEM writes a register that ID uses), independent of memread.
REQ-036 Without PIPE_HAZARD_FWD_EN, WB SHALL NOT cause a stall; the register file writes before it reads.

Verification
REQ-037 Load to r3, then add reading r3 (FWD_EN): 1 stall cycle (pc_write=0, idex_bubble=1), then fwd_a=10 in the add's EX cycle; stall_cnt=1.
REQ-038 add r2 then sub reading r2 back-to-back (FWD_EN): no stall; fwd_a=01 in the sub's EX cycle.
REQ-039 Back-to-back writes to r5 from MEM and WB, EX reads r5: fwd_b=01, showing MEM priority over WB.
REQ-040 Load-use hazard coinciding with ex_branch_taken=1: no stall, ifid_flush=idex_flush=1; EX.valid=0 next cycle; stall_cnt unchanged.
REQ-041 Write to r0 followed by a read of r0 (ZERO_REG=1): no stall, fwd=00.
REQ-042 PIPE_HAZARD_FWD_EN undefined, add r2 then dependent read of r2: 2 stall cycles; CNT_W=2 with 5 stalls gives stall_cnt=3 (saturated); rst mid-stall gives pc_write=1 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stall detection, branch flush and EX operand forwarding.
// Optional feature macro: PIPE_HAZARD_FWD_EN (defined = EX/MEM and MEM/WB forwarding; undefined = stall until write-back).
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } dst_t;

  typedef struct packed {
    dst_t              dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } ex_t;

  ex_t              ex_q, ex_d;
  dst_t             mem_q, mem_d;
  dst_t             wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;
  logic             stall;

  // A stage produces register r; register 0 never counts when hard-wired.
  function automatic logic writes(input dst_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  function automatic logic src_hit(input dst_t s,
                                   input logic [REG_AW-1:0] rs, input logic use_rs,
                                   input logic [REG_AW-1:0] rt, input logic use_rt);
    return (use_rs && writes(s, rs)) || (use_rt && writes(s, rt));
  endfunction

`ifdef PIPE_HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input dst_t m, input dst_t w,
                                         input logic use_r, input logic [REG_AW-1:0] r);
    if (use_r && writes(m, r)) return 2'b01;
    if (use_r && writes(w, r)) return 2'b10;
    return 2'b00;
  endfunction

  // Only a load in EX cannot be forwarded in time.
  assign hazard = id_valid && ex_q.dst.memread &&
                  src_hit(ex_q.dst, id_rs, id_use_rs, id_rt, id_use_rt);
  assign fwd_a  = ex_q.dst.valid ? fwd_sel(mem_q, wb_q, ex_q.use_rs, ex_q.rs) : 2'b00;
  assign fwd_b  = ex_q.dst.valid ? fwd_sel(mem_q, wb_q, ex_q.use_rt, ex_q.rt) : 2'b00;

  logic unused_bits;
  assign unused_bits = ^{mem_q.memread, wb_q.memread};
`else
  // Register file writes in the first half-cycle, so a producer in WB is already visible.
  assign hazard = id_valid &&
                  (src_hit(ex_q.dst,  id_rs, id_use_rs, id_rt, id_use_rt) ||
                   src_hit(mem_q,     id_rs, id_use_rs, id_rt, id_use_rt));
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{wb_q, mem_q.memread, ex_q.dst.memread, ex_q.rs, ex_q.rt,
                         ex_q.use_rs, ex_q.use_rt};
`endif

  assign stall       = hazard && !ex_branch_taken;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall;
  assign ifid_flush  = ex_branch_taken;
  assign idex_flush  = ex_branch_taken;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    ex_d        = '0;
    mem_d       = ex_q.dst;
    wb_d        = mem_q;
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !stall && !ex_branch_taken) begin
      ex_d.dst.valid    = 1'b1;
      ex_d.dst.rd       = id_rd;
      ex_d.dst.regwrite = id_regwrite;
      ex_d.dst.memread  = id_memread;
      ex_d.rs           = id_rs;
      ex_d.rt           = id_rt;
      ex_d.use_rs       = id_use_rs;
      ex_d.use_rt       = id_use_rt;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
